tt_analog_cfg_seq: RTL and testbench
====================================

Name: tt_analog_cfg_seq

Overview:
Configuration sequencer for the analog macro on the `ua` pins.
- Collects a CHAIN_BITS-wide configuration word from the digital host one byte at a time.
- On command, serially shifts the word into the macro's configuration chain using a divided serial clock, then pulses a latch strobe.
- Sits between the top-level `ui_in`/`uio` pin mapping and the analog macro's config chain, and owns all sequencing of that chain.

Parameters:
- CHAIN_BITS, 32: configuration chain length in bits; must be a multiple of 8 and at least 8.
- CLK_DIV, 4: system clocks per serial-clock half period; must be at least 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  design enable; when low, all state holds.
- wr_valid  in  1  host byte valid.
- wr_data  in  8  host config byte.
- wr_ready  out  1  byte can be accepted.
- start  in  1  single-cycle command to begin shifting.
- busy  out  1  shift or latch in progress.
- done  out  1  single-cycle pulse when the sequence completes.
- err  out  1  single-cycle pulse when a start is rejected.
- cfg_sclk  out  1  serial clock to the chain.
- cfg_sdata  out  1  serial data to the chain.
- cfg_latch  out  1  latch strobe to the chain.
- cfg_sdo  in  1  chain tail output (used only with READBACK_EN).
- rd_sel  in  $clog2(CHAIN_BITS/8)  readback byte select.
- rd_data  out  8  readback byte.

Behaviour:
- Reset (async assert, deasserted on clk):
  - State IDLE, load count 0, load register 0.
  - wr_ready=1; busy, done, err, cfg_sclk, cfg_sdata, cfg_latch, rd_data all 0.
- NBYTES = CHAIN_BITS/8.
- Byte load:
  - A byte is accepted when wr_valid && wr_ready && ena.
  - The byte at load count k is written to load register bits [8k+7:8k]; the count then increments.
  - wr_ready = (state==IDLE) && (count<NBYTES).
  - When the register is full, wr_ready=0 and further writes are ignored, with no overwrite.
- Start:
  - Accepted only when state==IDLE, count==NBYTES and ena.
  - A start in any other condition produces err=1 for exactly one cycle and no other effect.
  - If start and the last wr_valid arrive in the same cycle, the byte is accepted and the start is rejected (err).
  - A start while busy is also rejected (err).
- States:
  - IDLE -> SHIFT on an accepted start.
  - SHIFT -> LATCH after CHAIN_BITS bits.
  - LATCH -> DONE after CLK_DIV cycles.
  - DONE -> IDLE after 1 cycle.
- SHIFT timing:
  - Bits are sent MSB first, bit CHAIN_BITS-1 first.
  - Each bit: cfg_sdata is stable for 2*CLK_DIV cycles; cfg_sclk is low for the first CLK_DIV cycles and high for the second CLK_DIV cycles.
  - The chain samples on the cfg_sclk rising edge.
  - cfg_sdata changes only while cfg_sclk is low.
- LATCH: cfg_latch=1, cfg_sclk=0, cfg_sdata=0.
- DONE:
  - done=1 for one cycle.
  - Load count cleared to 0; load register retains its value.
  - Then IDLE, wr_ready=1.
- busy=1 in SHIFT, LATCH and DONE.
- Latency: with start accepted in cycle 0, done is high in cycle 1 + 2*CLK_DIV*CHAIN_BITS + CLK_DIV. With defaults this is cycle 261.
- ena=0: all counters, timers, state and outputs freeze; resume exactly on ena=1.
- Reset mid-sequence: immediate return to reset values; the partially shifted chain is not latched (cfg_latch stays 0).

Optional Feature:
- Macro: TT_ANALOG_CFG_READBACK_EN.
- When defined:
  - cfg_sdo is sampled in the cycle cfg_sclk rises.
  - The sample is shifted into a CHAIN_BITS readback register, LSB entry, so after the full shift the first bit returned occupies the MSB.
  - rd_data = readback[8*rd_sel+7 : 8*rd_sel], combinational from the register.
  - The readback register is reset to 0 and is not cleared by DONE.
- When undefined: cfg_sdo is unused, no readback register is built, rd_data is tied to 0.

Decomposition:
- Package tt_analog_cfg_pkg:
  - State enum: IDLE, SHIFT, LATCH, DONE.
  - Function nbytes(CHAIN_BITS).
  - Constant for the load-count width.
- One sub-module, tt_cfg_phase_timer: counts CLK_DIV cycles with ena gating and emits a single-cycle phase_end tick; used for the sclk half periods and the latch period.

Test Plan:
- Reset values, then write bytes 0x11, 0x22, 0x33, 0x44 -> wr_ready falls after the 4th byte; a 5th write is ignored.
- Full register 0x44332211, start -> sdata bit sequence on sclk rises is 0,1,0,0,0,1,0,0,...; latch high for 4 cycles; done in cycle 261.
- Start with only 2 bytes loaded, or start during SHIFT -> err pulse of 1 cycle, state unchanged.
- ena low for 10 cycles mid-SHIFT -> sclk and sdata frozen; done delayed by exactly 10 cycles.
- rst_n asserted mid-SHIFT -> all outputs 0 immediately; no latch pulse; wr_ready=1 after release.
- With READBACK_EN, cfg_sdo looped from a 32-bit model chain preloaded with 0xA5A5_0F0F -> rd_data for rd_sel 0..3 reads 0x0F, 0x0F, 0xA5, 0xA5.

Source files
------------

// File: rtl/tt_analog_cfg_pkg.sv
// Shared types and sizing helpers for the analog configuration-chain sequencer.
package tt_analog_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2,
      DONE  = 2'd3
   } cfg_state_e;

   function automatic int nbytes(input int chain_bits);
      return chain_bits / 8;
   endfunction

   // Load count must be able to hold NBYTES itself, hence the +1.
   function automatic int load_cnt_w(input int chain_bits);
      return $clog2(nbytes(chain_bits) + 1);
   endfunction

   localparam int LOAD_CNT_W_DEFAULT = load_cnt_w(32);

endpackage

// File: rtl/tt_cfg_phase_timer.sv
// CLK_DIV-cycle phase timer with enable gating; phase_end ticks on the last cycle of each phase.
module tt_cfg_phase_timer #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic run,
   output logic phase_end
);

   localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [TW-1:0] cnt_q, cnt_d;

   assign phase_end = run && ena && (cnt_q == TW'(CLK_DIV - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (!run) begin
         cnt_d = '0;
      end else if (ena) begin
         cnt_d = phase_end ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tt_analog_cfg_seq.sv
// Loads a CHAIN_BITS config word bytewise, shifts it MSB-first into the analog chain, then latches.
// Optional chain readback is enabled by defining TT_ANALOG_CFG_READBACK_EN.
module tt_analog_cfg_seq
   import tt_analog_cfg_pkg::*;
#(
   parameter int CHAIN_BITS = 32,
   parameter int CLK_DIV    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       wr_valid,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       cfg_sclk,
   output logic       cfg_sdata,
   output logic       cfg_latch,
   input  logic       cfg_sdo,
   input  logic [((CHAIN_BITS > 8) ? $clog2(CHAIN_BITS/8) : 1)-1:0] rd_sel,
   output logic [7:0] rd_data
);

   localparam int NBYTES = nbytes(CHAIN_BITS);
   localparam int CNT_W  = load_cnt_w(CHAIN_BITS);
   localparam int BIT_W  = (CHAIN_BITS > 1) ? $clog2(CHAIN_BITS) : 1;
   localparam int RSEL_W = (CHAIN_BITS > 8) ? $clog2(CHAIN_BITS/8) : 1;

   cfg_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CHAIN_BITS-1:0]  load_q, load_d;
   logic [BIT_W-1:0]       bit_q, bit_d;
   logic                   half_q, half_d;
   logic                   err_q, err_d;
   logic                   phase_end;
   logic                   start_ok;
   logic                   wr_acc;

   tt_cfg_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .run       ((state_q == SHIFT) || (state_q == LATCH)),
      .phase_end (phase_end)
   );

   assign wr_ready  = (state_q == IDLE) && (cnt_q < CNT_W'(NBYTES));
   assign start_ok  = (state_q == IDLE) && (cnt_q == CNT_W'(NBYTES));
   assign wr_acc    = ena && wr_valid && wr_ready;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign err       = err_q;
   assign cfg_latch = (state_q == LATCH);
   assign cfg_sclk  = (state_q == SHIFT) && half_q;
   assign cfg_sdata = (state_q == SHIFT) && load_q[bit_q];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load_d  = load_q;
      bit_d   = bit_q;
      half_d  = half_q;
      err_d   = err_q;
      if (ena) begin
         err_d = start && !start_ok;
         // A byte write and an accepted start are mutually exclusive via the count.
         if (wr_acc) begin
            for (int b = 0; b < NBYTES; b++) begin
               if (cnt_q == CNT_W'(b)) load_d[8*b +: 8] = wr_data;
            end
            cnt_d = cnt_q + 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (start && start_ok) begin
                  state_d = SHIFT;
                  bit_d   = BIT_W'(CHAIN_BITS - 1);
                  half_d  = 1'b0;
               end
            end
            SHIFT: begin
               if (phase_end) begin
                  if (!half_q) begin
                     half_d = 1'b1;
                  end else begin
                     half_d = 1'b0;
                     if (bit_q == '0) state_d = LATCH;
                     else             bit_d   = bit_q - 1'b1;
                  end
               end
            end
            LATCH: begin
               if (phase_end) state_d = DONE;
            end
            DONE: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         load_q  <= '0;
         bit_q   <= '0;
         half_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         load_q  <= load_d;
         bit_q   <= bit_d;
         half_q  <= half_d;
         err_q   <= err_d;
      end
   end

`ifdef TT_ANALOG_CFG_READBACK_EN
   logic [CHAIN_BITS-1:0] rb_q, rb_d;

   // Sample on the edge that raises sclk, before the chain itself shifts.
   always_comb begin
      rb_d = rb_q;
      if ((state_q == SHIFT) && phase_end && !half_q) begin
         rb_d = {rb_q[CHAIN_BITS-2:0], cfg_sdo};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rb_q <= '0;
      end else begin
         rb_q <= rb_d;
      end
   end

   always_comb begin
      rd_data = 8'h00;
      for (int b = 0; b < NBYTES; b++) begin
         if (rd_sel == RSEL_W'(b)) rd_data = rb_q[8*b +: 8];
      end
   end
`else
   logic unused_rb;
   assign unused_rb = ^{cfg_sdo, rd_sel};
   assign rd_data   = 8'h00;
`endif

endmodule

// File: tb/tb_tt_analog_cfg_seq.sv
// Scoreboard bench for tt_analog_cfg_seq: load, shift order, latch/done timing, errors, freeze, reset.
module tb_tt_analog_cfg_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       start;
   logic       busy, done, err;
   logic       cfg_sclk, cfg_sdata, cfg_latch, cfg_sdo;
   logic [1:0] rd_sel;
   logic [7:0] rd_data;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] tb_word;
   int          tb_cnt;
   bit          exp_q[$];

   always #5 clk = ~clk;

   tt_analog_cfg_seq #(.CHAIN_BITS(32), .CLK_DIV(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .wr_valid  (wr_valid),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .cfg_sclk  (cfg_sclk),
      .cfg_sdata (cfg_sdata),
      .cfg_latch (cfg_latch),
      .cfg_sdo   (cfg_sdo),
      .rd_sel    (rd_sel),
      .rd_data   (rd_data)
   );

`ifdef TT_ANALOG_CFG_READBACK_EN
   logic [31:0] chain;
   logic        preload_stb = 1'b0;
   always @(posedge cfg_sclk or posedge preload_stb) begin
      if (preload_stb) chain <= 32'hA5A5_0F0F;
      else             chain <= {chain[30:0], cfg_sdata};
   end
   assign cfg_sdo = chain[31];
`else
   assign cfg_sdo = 1'b0;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_byte(input logic [7:0] b, input logic with_start);
      wr_valid = 1'b1;
      wr_data  = b;
      start    = with_start;
      if (tb_cnt < 4) begin
         tb_word[8*tb_cnt +: 8] = b;
         tb_cnt++;
      end
      tick();
      wr_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ena = 1'b1; wr_valid = 1'b0; wr_data = 8'h00; start = 1'b0; rd_sel = 2'd0;
      tb_word = 32'h0; tb_cnt = 0;
      repeat (3) tick();
      n_cmp++;
      if ({wr_ready, busy, done, err, cfg_sclk, cfg_sdata, cfg_latch} !== 7'b1000000) begin
         n_err++;
         $display("FAIL reset_outputs got=%b want=1000000",
                  {wr_ready, busy, done, err, cfg_sclk, cfg_sdata, cfg_latch});
      end
      n_cmp++;
      if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data got=%h want=00", rd_data); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_load();
      logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (wr_ready !== 1'b1) begin n_err++; $display("FAIL load_ready_%0d got=%b want=1", k, wr_ready); end
         write_byte(bytes[k], 1'b0);
      end
      n_cmp++;
      if (wr_ready !== 1'b0) begin n_err++; $display("FAIL load_full_ready got=%b want=0", wr_ready); end
      write_byte(8'h55, 1'b0);
      n_cmp++;
      if ({wr_ready, busy, err} !== 3'b000) begin
         n_err++; $display("FAIL load_overflow got=%b want=000", {wr_ready, busy, err});
      end
   endtask

   // Runs one full start/shift/latch/done sequence; freeze_at>=0 drops ena for 10 cycles there.
   task automatic run_seq(input string tag, input int freeze_at);
      int cyc, latch_n, done_at, want_done;
      bit prev_sclk, prev_sdata, fz_sclk, fz_sdata, got;
      want_done = 261 + ((freeze_at >= 0) ? 10 : 0);
      exp_q.delete();
      for (int i = 31; i >= 0; i--) exp_q.push_back(tb_word[i]);
`ifdef TT_ANALOG_CFG_READBACK_EN
      preload_stb = 1'b1; #1 preload_stb = 1'b0;
`endif
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL %s_busy got=%b want=1", tag, busy); end
      prev_sclk = 1'b0; prev_sdata = cfg_sdata; latch_n = 0; done_at = -1;
      while (cyc < 600 && done_at < 0) begin
         if (cyc == freeze_at) begin
            ena = 1'b0; fz_sclk = cfg_sclk; fz_sdata = cfg_sdata;
            repeat (10) begin
               tick(); cyc++;
               n_cmp++;
               if ({cfg_sclk, cfg_sdata} !== {fz_sclk, fz_sdata}) begin
                  n_err++;
                  $display("FAIL %s_freeze cyc=%0d got=%b%b want=%b%b", tag, cyc, cfg_sclk, cfg_sdata, fz_sclk, fz_sdata);
               end
            end
            ena = 1'b1;
         end
         if (cfg_sclk && !prev_sclk) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++; $display("FAIL %s_extra_bit cyc=%0d got=sclk rise want=none", tag, cyc);
            end else begin
               got = exp_q.pop_front();
               if (cfg_sdata !== got) begin
                  n_err++; $display("FAIL %s_sdata cyc=%0d got=%b want=%b", tag, cyc, cfg_sdata, got);
               end
            end
         end
         if (cfg_sclk && prev_sclk) begin
            n_cmp++;
            if (cfg_sdata !== prev_sdata) begin
               n_err++; $display("FAIL %s_sdata_while_high cyc=%0d got=%b want=%b", tag, cyc, cfg_sdata, prev_sdata);
            end
         end
         if (cfg_latch) begin
            latch_n++;
            n_cmp++;
            if ({cfg_sclk, cfg_sdata} !== 2'b00) begin
               n_err++; $display("FAIL %s_latch_lines got=%b%b want=00", tag, cfg_sclk, cfg_sdata);
            end
         end
         if (done) done_at = cyc;
         else begin
            prev_sclk = cfg_sclk; prev_sdata = cfg_sdata;
            tick(); cyc++;
         end
      end
      n_cmp++;
      if (done_at != want_done) begin n_err++; $display("FAIL %s_done_cycle got=%0d want=%0d", tag, done_at, want_done); end
      n_cmp++;
      if (latch_n != 4) begin n_err++; $display("FAIL %s_latch_len got=%0d want=4", tag, latch_n); end
      n_cmp++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL %s_bits_left got=%0d want=0", tag, exp_q.size()); end
      tick();
      n_cmp++;
      if ({done, busy, wr_ready} !== 3'b001) begin
         n_err++; $display("FAIL %s_after_done got=%b want=001", tag, {done, busy, wr_ready});
      end
      tb_cnt = 0;
      for (int s = 0; s < 4; s++) begin
         logic [7:0] want_rd;
`ifdef TT_ANALOG_CFG_READBACK_EN
         logic [31:0] pre = 32'hA5A5_0F0F;
         want_rd = pre[8*s +: 8];
`else
         want_rd = 8'h00;
`endif
         rd_sel = s[1:0];
         #1;
         n_cmp++;
         if (rd_data !== want_rd) begin n_err++; $display("FAIL %s_rd_data sel=%0d got=%h want=%h", tag, s, rd_data, want_rd); end
      end
   endtask

   task automatic test_early_start();
      write_byte(8'h11, 1'b0);
      write_byte(8'h22, 1'b0);
      start = 1'b1; tick(); start = 1'b0;
      n_cmp++;
      if ({err, busy, wr_ready} !== 3'b101) begin
         n_err++; $display("FAIL early_start got=%b want=101", {err, busy, wr_ready});
      end
      tick();
      n_cmp++;
      if (err !== 1'b0) begin n_err++; $display("FAIL early_err_width got=%b want=0", err); end
      write_byte(8'h33, 1'b0);
      write_byte(8'h44, 1'b1);
      n_cmp++;
      if ({err, busy, wr_ready} !== 3'b100) begin
         n_err++; $display("FAIL last_byte_start got=%b want=100", {err, busy, wr_ready});
      end
      tick();
      n_cmp++;
      if (err !== 1'b0) begin n_err++; $display("FAIL last_byte_err_width got=%b want=0", err); end
   endtask

   task automatic test_busy_start();
      int cyc;
      write_byte(8'h5A, 1'b0); write_byte(8'hC3, 1'b0); write_byte(8'h01, 1'b0); write_byte(8'h80, 1'b0);
      start = 1'b1; tick(); start = 1'b0;
      cyc = 1;
      repeat (19) begin tick(); cyc++; end
      start = 1'b1; tick(); start = 1'b0; cyc++;
      n_cmp++;
      if ({err, busy} !== 2'b11) begin n_err++; $display("FAIL busy_start got=%b want=11", {err, busy}); end
      tick(); cyc++;
      n_cmp++;
      if (err !== 1'b0) begin n_err++; $display("FAIL busy_err_width got=%b want=0", err); end
      while (!done && cyc < 600) begin tick(); cyc++; end
      n_cmp++;
      if (cyc != 261) begin n_err++; $display("FAIL busy_done_cycle got=%0d want=261", cyc); end
      tick();
      tb_cnt = 0;
   endtask

   task automatic test_reset_mid();
      int latch_n;
      write_byte(8'hDE, 1'b0); write_byte(8'hAD, 1'b0); write_byte(8'hBE, 1'b0); write_byte(8'hEF, 1'b0);
      start = 1'b1; tick(); start = 1'b0;
      repeat (50) tick();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, cfg_sclk, cfg_sdata, cfg_latch, done, err, wr_ready} !== 7'b0000001) begin
         n_err++;
         $display("FAIL reset_mid got=%b want=0000001", {busy, cfg_sclk, cfg_sdata, cfg_latch, done, err, wr_ready});
      end
      tick(); tick();
      rst_n = 1'b1;
      tb_word = 32'h0; tb_cnt = 0;
      latch_n = 0;
      repeat (300) begin tick(); if (cfg_latch) latch_n++; end
      n_cmp++;
      if (latch_n != 0 || busy !== 1'b0) begin
         n_err++; $display("FAIL reset_mid_latch got=%0d/%b want=0/0", latch_n, busy);
      end
      n_cmp++;
      if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_mid_ready got=%b want=1", wr_ready); end
   endtask

   initial begin
      test_reset();
      test_load();
      run_seq("shift", -1);
      test_early_start();
      run_seq("freeze", 100);
      test_busy_start();
      test_reset_mid();
      write_byte(8'hDE, 1'b0); write_byte(8'hAD, 1'b0); write_byte(8'hBE, 1'b0); write_byte(8'hEF, 1'b0);
      run_seq("pattern2", -1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
